// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the staged reset-release sequencer.
//   - FSM state encodings (ASSERT, WAIT_ACK, GAP, DONE, ERR)
//   - stage-index width (stages 0..7)
//   - status struct carried by the registered output decode
//   - stg_held(): whether a stage's reset is held in a given state
package rst_seq_ctrl_pkg;

  localparam int STG_IDX_W = 3;

  localparam logic [2:0] ST_ASSERT = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [STG_IDX_W-1:0] err_stg;
  } sts_t;

  // Stage idx is held in reset unless it has been released in state st with current stage k.
  // In WAIT/GAP stages 0..k are out; in ERR stage k itself goes back into reset.
  function automatic logic stg_held(input logic [2:0]           st,
                                    input logic [STG_IDX_W-1:0] idx,
                                    input logic [STG_IDX_W-1:0] k);
    case (st)
      ST_WAIT, ST_GAP: return idx > k;
      ST_DONE:         return 1'b0;
      ST_ERR:          return idx >= k;
      default:         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_cyc_timer.sv
// cyc_timer: clear/enable up-counter with a saturating terminal compare.
// One instance serves the lock-hold, inter-stage gap and ack-timeout phases.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : zero the count (wins over i_en)
//   i_en     : count this cycle
//   i_term   : terminal count for the current phase (>=1)
//   o_hit    : this enabled cycle is the i_term-th counted cycle
module cyc_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;

  // r_cnt holds the number of cycles already counted, so the current
  // enabled cycle is number r_cnt+1. Compare with >= so a saturated
  // count still reports a hit.
  assign o_hit = i_en & (r_cnt >= (i_term - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset-release sequencer.
// Holds N_STG downstream blocks in reset until lock_i has been stable for
// HOLD_CYC cycles, then releases them in order 0..N_STG-1, waiting for each
// stage's ack (ACK_TMO cycle limit) and inserting GAP_CYC idle cycles between.
//   clk, rst      : clock, synchronous active-high reset
//   lock_i        : clock source stable (level)
//   sw_rst_req_i  : software re-sequence request (pulse)
//   stg_ack_i     : per-stage init-done (level)
//   stg_rst_o     : per-stage active-high reset (registered)
//   busy_o/done_o : sequence in progress / all stages released and acked
//   err_o         : ack timeout; err_stg_o is the stage that timed out
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_STG    = 4,
  parameter int HOLD_CYC = 10,
  parameter int GAP_CYC  = 4,
  parameter int ACK_TMO  = 255,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lock_i,
  input  logic                 sw_rst_req_i,
  input  logic [N_STG-1:0]     stg_ack_i,
  output logic [N_STG-1:0]     stg_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [STG_IDX_W-1:0] err_stg_o
);

  localparam logic [STG_IDX_W-1:0] LAST = STG_IDX_W'(N_STG - 1);

  logic [2:0]           r_state;
  logic [STG_IDX_W-1:0] r_stg;
  logic [N_STG-1:0]     r_stg_rst;
  sts_t                 r_sts;

  logic [2:0]           w_nstate;
  logic [STG_IDX_W-1:0] w_nstg;
  logic [N_STG-1:0]     w_nrst;
  sts_t                 w_nsts;
  logic                 w_abort;
  logic                 w_ack_k;
  logic                 w_tclr;
  logic                 w_ten;
  logic                 w_hit;
  logic [CNT_W-1:0]     w_term;

  // ack of the stage currently waited on; the others are ignored
  always_comb begin
    w_ack_k = 1'b0;
    for (int i = 0; i < N_STG; i++)
      if (r_stg == STG_IDX_W'(i)) w_ack_k = stg_ack_i[i];
  end

  // timer phase select: lock-hold in ASSERT, gap in GAP, timeout otherwise
  always_comb begin
    case (r_state)
      ST_ASSERT: begin w_ten = lock_i; w_term = CNT_W'(HOLD_CYC); end
      ST_GAP:    begin w_ten = 1'b1;   w_term = CNT_W'(GAP_CYC);  end
      ST_WAIT:   begin w_ten = 1'b1;   w_term = CNT_W'(ACK_TMO);  end
      default:   begin w_ten = 1'b0;   w_term = CNT_W'(ACK_TMO);  end
    endcase
  end

  cyc_timer #(.CNT_W(CNT_W)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tclr),
    .i_en   (w_ten),
    .i_term (w_term),
    .o_hit  (w_hit)
  );

  // next-state logic; every phase change restarts the shared timer
  always_comb begin
    w_nstate = r_state;
    w_nstg   = r_stg;
    w_tclr   = 1'b0;
    w_abort  = sw_rst_req_i | (~lock_i & (r_state != ST_ASSERT));
    if (w_abort) begin
      w_nstate = ST_ASSERT;
      w_nstg   = '0;
      w_tclr   = 1'b1;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (!lock_i) begin
            w_tclr = 1'b1;                // hold count must be consecutive
          end else if (w_hit) begin
            w_nstate = ST_WAIT;
            w_nstg   = '0;
            w_tclr   = 1'b1;
          end
        end
        ST_WAIT: begin
          // ack checked first so ack-on-timeout-cycle is not an error
          if (w_ack_k) begin
            w_tclr = 1'b1;
            if (r_stg == LAST)     w_nstate = ST_DONE;
            else if (GAP_CYC == 0) w_nstg   = r_stg + STG_IDX_W'(1);
            else                   w_nstate = ST_GAP;
          end else if (w_hit) begin
            w_nstate = ST_ERR;
            w_tclr   = 1'b1;
          end
        end
        ST_GAP: begin
          if (w_hit) begin
            w_nstate = ST_WAIT;
            w_nstg   = r_stg + STG_IDX_W'(1);
            w_tclr   = 1'b1;
          end
        end
        ST_DONE, ST_ERR: ;              // left only via abort or rst
        default: begin
          w_nstate = ST_ASSERT;
          w_nstg   = '0;
          w_tclr   = 1'b1;
        end
      endcase
    end
  end

  // output decode from next state so outputs line up with the state register
  for (genvar g = 0; g < N_STG; g++) begin : g_stg
    assign w_nrst[g] = stg_held(w_nstate, STG_IDX_W'(g), w_nstg);
  end

  always_comb begin
    w_nsts.busy    = (w_nstate == ST_ASSERT) || (w_nstate == ST_WAIT) || (w_nstate == ST_GAP);
    w_nsts.done    = (w_nstate == ST_DONE);
    w_nsts.err     = (w_nstate == ST_ERR);
    w_nsts.err_stg = (w_nstate == ST_ERR) ? w_nstg : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ASSERT;
      r_stg     <= '0;
      r_stg_rst <= '1;
      r_sts     <= '{busy: 1'b1, done: 1'b0, err: 1'b0, err_stg: '0};
    end else begin
      r_state   <= w_nstate;
      r_stg     <= w_nstg;
      r_stg_rst <= w_nrst;
      r_sts     <= w_nsts;
    end
  end

  assign stg_rst_o = r_stg_rst;
  assign busy_o    = r_sts.busy;
  assign done_o    = r_sts.done;
  assign err_o     = r_sts.err;
  assign err_stg_o = r_sts.err_stg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a stage-count model checked every cycle against
// the default-parameter DUT, directed literal checks on key cycles, and a
// second GAP_CYC=0 instance with acks tied high.
module tb_rst_seq_ctrl;

  localparam int N    = 4;
  localparam int HOLD = 10;
  localparam int GAP  = 4;
  localparam int TMO  = 255;

  logic       clk, rst, lock, sw;
  logic [3:0] ack;
  logic       sw2;
  logic [3:0] ack2;

  logic [3:0] stg_rst;
  logic       busy, done, err;
  logic [2:0] err_stg;
  logic [3:0] stg_rst2;
  logic       busy2, done2, err2;
  logic [2:0] err_stg2;

  int n_chk, n_err, cyc;
  int dly [4];
  int age [4];

  rst_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .lock_i(lock), .sw_rst_req_i(sw), .stg_ack_i(ack),
    .stg_rst_o(stg_rst), .busy_o(busy), .done_o(done), .err_o(err), .err_stg_o(err_stg)
  );

  rst_seq_ctrl #(.GAP_CYC(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .lock_i(lock), .sw_rst_req_i(sw2), .stg_ack_i(ack2),
    .stg_rst_o(stg_rst2), .busy_o(busy2), .done_o(done2), .err_o(err2), .err_stg_o(err_stg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // Ack responder: stage k raises its ack dly[k] cycles into its release
  // (age 1 = first released cycle) and keeps it high while released.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      if (!stg_rst[k]) age[k] = age[k] + 1;
      else             age[k] = 0;
      ack[k] = (age[k] >= dly[k]);
    end
  end

  // ---------------- behavioural model ----------------
  // m_rel = number of stages currently released; m_gap = idling after an ack;
  // m_cnt = cycles spent in the current phase.
  int m_rel, m_cnt, m_ek;
  bit m_gap, m_done, m_err, m_valid;

  always @(posedge clk) begin
    bit in_hold;
    in_hold = (m_rel == 0) && !m_err && !m_done;
    if (rst || sw || (!lock && !in_hold)) begin
      m_rel = 0; m_cnt = 0; m_gap = 0; m_done = 0; m_err = 0; m_ek = 0;
    end else if (m_err || m_done) begin
      // parked
    end else if (m_rel == 0) begin
      if (lock) begin
        m_cnt++;
        if (m_cnt == HOLD) begin m_rel = 1; m_cnt = 0; end
      end else m_cnt = 0;
    end else if (m_gap) begin
      m_cnt++;
      if (m_cnt == GAP) begin m_gap = 0; m_rel++; m_cnt = 0; end
    end else begin
      m_cnt++;
      if (ack[m_rel-1]) begin
        m_cnt = 0;
        if (m_rel == N)    m_done = 1;
        else if (GAP == 0) m_rel++;
        else               m_gap = 1;
      end else if (m_cnt == TMO) begin
        m_err = 1; m_ek = m_rel - 1; m_rel = m_rel - 1; m_cnt = 0;
      end
    end
    m_valid = 1;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      logic [3:0] e_rst;
      for (int i = 0; i < 4; i++) e_rst[i] = m_done ? 1'b0 : !(i < m_rel);
      chk("model.stg_rst", 32'(stg_rst), 32'(e_rst));
      chk("model.busy",    32'(busy),    32'(!(m_done || m_err)));
      chk("model.done",    32'(done),    32'(m_done));
      chk("model.err",     32'(err),     32'(m_err));
      chk("model.err_stg", 32'(err_stg), m_err ? m_ek : 0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // reset for two edges, then cycle 0 is the first cycle with rst low
  task automatic start_run();
    rst = 1'b1; sw = 1'b0; lock = 1'b1;
    tick(); tick();
    rst = 1'b0; cyc = 0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    m_valid = 0; m_rel = 0; m_cnt = 0; m_gap = 0; m_done = 0; m_err = 0; m_ek = 0;
    rst = 1'b1; lock = 1'b0; sw = 1'b0; ack = '0;
    sw2 = 1'b0; ack2 = 4'hF;
    for (int k = 0; k < 4; k++) begin dly[k] = 3; age[k] = 0; end

    // reset values
    tick(); tick();
    chk("rst.stg_rst", 32'(stg_rst), 32'hF);
    chk("rst.busy",    32'(busy),    1);
    chk("rst.done",    32'(done),    0);
    chk("rst.err",     32'(err),     0);
    chk("rst.err_stg", 32'(err_stg), 0);

    // 1. nominal: acks 2 cycles after release, releases at 10,17,24,31, done at 34
    //    5. GAP_CYC=0 instance with acks high: releases 10..13, done at 14
    start_run();
    run_to(9);  chk("nom.hold9",  32'(stg_rst), 32'hF);  chk("g0.c9",  32'(stg_rst2), 32'hF);
    run_to(10); chk("nom.rel0",   32'(stg_rst), 32'hE);  chk("g0.c10", 32'(stg_rst2), 32'hE);
    run_to(11); chk("g0.c11", 32'(stg_rst2), 32'hC);
    run_to(12); chk("g0.c12", 32'(stg_rst2), 32'h8);
    run_to(13); chk("g0.c13", 32'(stg_rst2), 32'h0);     chk("g0.done13", 32'(done2), 0);
    run_to(14); chk("g0.done14", 32'(done2), 1);          chk("g0.busy14", 32'(busy2), 0);
    run_to(16); chk("nom.gap16",  32'(stg_rst), 32'hE);
    run_to(17); chk("nom.rel1",   32'(stg_rst), 32'hC);
    run_to(33); chk("nom.done33", 32'(done),    0);
    run_to(34); chk("nom.done34", 32'(done),    1);
    chk("nom.allrel", 32'(stg_rst), 32'h0);
    chk("nom.noerr",  32'(err),     0);
    chk("nom.idle",   32'(busy),    0);
    // lock loss in DONE aborts
    lock = 1'b0; tick(); lock = 1'b1;
    chk("lockloss.stg_rst", 32'(stg_rst), 32'hF);
    chk("lockloss.busy",    32'(busy),    1);

    // 2. lock glitch at hold count 7: stage 0 released 10 cycles after lock returns
    start_run();
    run_to(7); lock = 1'b0;
    run_to(8); lock = 1'b1;
    run_to(17); chk("glitch.hold", 32'(stg_rst), 32'hF);
    run_to(18); chk("glitch.rel0", 32'(stg_rst), 32'hE);

    // 3. stage 2 never acks: released at 24, error at 24+255
    dly[2] = 100000;
    start_run();
    run_to(278); chk("tmo.pre",     32'(err),     0);  chk("tmo.pre_rst", 32'(stg_rst), 32'h8);
    run_to(279); chk("tmo.err",     32'(err),     1);
    chk("tmo.err_stg", 32'(err_stg), 2);
    chk("tmo.stg_rst", 32'(stg_rst), 32'hC);
    chk("tmo.busy",    32'(busy),    0);
    run_to(285); chk("tmo.sticky", 32'(err), 1);
    sw = 1'b1; tick(); sw = 1'b0;
    chk("tmo.sw_rst",  32'(stg_rst), 32'hF);
    chk("tmo.sw_busy", 32'(busy),    1);
    chk("tmo.sw_err",  32'(err),     0);
    dly[2] = 3;
    run_to(295); chk("tmo.rehold", 32'(stg_rst), 32'hF);
    run_to(296); chk("tmo.rerel0", 32'(stg_rst), 32'hE);

    // 4. sw request in GAP(1) (cycles 20..23)
    start_run();
    run_to(21); chk("abort.pre", 32'(stg_rst), 32'hC);
    sw = 1'b1; tick(); sw = 1'b0;
    chk("abort.stg_rst", 32'(stg_rst), 32'hF);
    chk("abort.busy",    32'(busy),    1);
    chk("abort.done",    32'(done),    0);

    // 6a. stage 0 acks on its 255th wait cycle: ack wins, stage 1 out at 269
    dly[0] = 255;
    start_run();
    run_to(264); chk("race.wait", 32'(stg_rst), 32'hE);
    run_to(265); chk("race.noerr", 32'(err), 0);  chk("race.gap", 32'(stg_rst), 32'hE);
    run_to(269); chk("race.rel1", 32'(stg_rst), 32'hC);
    dly[0] = 3;

    // 6b. rst in WAIT_ACK(3) (stage 3 out at 31)
    start_run();
    run_to(32); chk("wrst.pre", 32'(stg_rst), 32'h0);  chk("wrst.pre_done", 32'(done), 0);
    rst = 1'b1; tick();
    chk("wrst.stg_rst", 32'(stg_rst), 32'hF);
    chk("wrst.busy",    32'(busy),    1);
    chk("wrst.done",    32'(done),    0);
    chk("wrst.err",     32'(err),     0);
    rst = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
